// File: rtl/usart_tx.sv
// UART transmitter: serialises one byte per valid/ready handshake onto txd.
// Frame is LSB first: start(0), UART_BIT data bits, optional parity, stop(1).
module usart_tx #(
    parameter int CLK_FRQ      = 50_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int UART_CNT_MAX = CLK_FRQ / BAUD_RATE,
    parameter int UART_BIT     = 8,
    parameter int PARITY       = 0
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam logic [19:0] BAUD_LAST = 20'(UART_CNT_MAX - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_BIT - 1);
    localparam logic        PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e      state_q;
    logic [19:0] baud_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        txd_q;
    logic        done_q;
    logic        baud_end;

    assign baud_end = (baud_cnt_q == BAUD_LAST);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_valid) begin
                        shift_q    <= tx_data;
                        parity_q   <= 1'b0;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 20'd1;
                    end
                end

                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        parity_q   <= parity_q ^ shift_q[0];
                        if (bit_cnt_q == BIT_LAST) begin
                            if (PARITY != 0) begin
                                // Fold in the bit just finished; parity_q is still one bit behind.
                                txd_q   <= parity_q ^ shift_q[0] ^ PAR_ODD;
                                state_q <= ST_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 20'd1;
                    end
                end

                ST_PARITY: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        txd_q      <= 1'b1;
                        state_q    <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 20'd1;
                    end
                end

                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        txd_q      <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 20'd1;
                    end
                end

                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = done_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx: fixed frame vectors, corner-case sequences,
// and random bytes decoded by a mid-bit sampling receiver model.
module tb_usart_tx;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    logic [4:0] tx_valid, tx_ready, tx_busy, tx_done, txd;
    logic [7:0] tx_data [5];

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: 8N1 M=434, 1: even M=434, 2: odd M=434, 3: 8N1 M=5, 4: 7O M=3
    usart_tx u_8n1 (
        .clock(clock), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .txd(txd[0]));
    usart_tx #(.PARITY(1)) u_even (
        .clock(clock), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .txd(txd[1]));
    usart_tx #(.PARITY(2)) u_odd (
        .clock(clock), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .txd(txd[2]));
    usart_tx #(.UART_CNT_MAX(5)) u_fast (
        .clock(clock), .rst_n(rst_n), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .txd(txd[3]));
    usart_tx #(.UART_CNT_MAX(3), .UART_BIT(7), .PARITY(2)) u_7o (
        .clock(clock), .rst_n(rst_n), .tx_data(tx_data[4]), .tx_valid(tx_valid[4]),
        .tx_ready(tx_ready[4]), .tx_busy(tx_busy[4]), .tx_done(tx_done[4]), .txd(txd[4]));

    function automatic int m_of(input int k);
        return (k == 3) ? 5 : (k == 4) ? 3 : 434;
    endfunction

    function automatic int ub_of(input int k);
        return (k == 4) ? 7 : 8;
    endfunction

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : (k == 2 || k == 4) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference frame: line bit i of the frame in bits[i], n bits in total.
    function automatic void model_frame(input logic [7:0] d, input int ub, input int par,
                                        output logic [11:0] bits, output int n);
        logic p;
        bits = '1;
        bits[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < ub; i++) begin
            bits[1 + i] = d[i];
            p ^= d[i];
        end
        n = ub + 2;
        if (par != 0) begin
            bits[ub + 1] = (par == 1) ? p : ~p;
            n++;
        end
        bits[n - 1] = 1'b1;
    endfunction

    task automatic send_frame(input int k, input logic [7:0] d, input logic [11:0] exp_bits,
                              input int nbits, input int done_t, input bit keep_valid,
                              input bit glitch, output longint done_at);
        int m;
        int ub;
        int t;
        int budget;
        bit early;
        logic [7:0] rx;
        logic [7:0] mask;
        m    = m_of(k);
        ub   = ub_of(k);
        mask = 8'((1 << ub) - 1);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        budget = 0;
        while (!tx_ready[k] && budget < 20000) begin
            tick();
            budget++;
        end
        check($sformatf("k%0d ready_wait", k), 32'(tx_ready[k]), 32'd1);
        tick();
        check($sformatf("k%0d accept_busy", k), 32'(tx_busy[k]), 32'd1);
        check($sformatf("k%0d accept_txd", k), 32'(txd[k]), 32'd0);
        if (!keep_valid) tx_valid[k] = 1'b0;
        t = 0;
        early = 1'b0;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            while (t < i * m + m / 2) begin
                tick();
                t++;
                if (tx_done[k]) early = 1'b1;
                if (glitch) begin
                    if (t == 4 * m) begin
                        tx_data[k]  = 8'hFF;
                        tx_valid[k] = 1'b1;
                    end else if (t == 4 * m + 1) begin
                        tx_valid[k] = 1'b0;
                    end
                end
            end
            check($sformatf("k%0d d%02h bit%0d", k, d, i), 32'(txd[k]), 32'(exp_bits[i]));
            if (i >= 1 && i <= ub) rx[i - 1] = txd[k];
        end
        check($sformatf("k%0d rx_byte", k), 32'(rx), 32'(d & mask));
        while (t < done_t - 1) begin
            tick();
            t++;
            if (tx_done[k]) early = 1'b1;
        end
        check($sformatf("k%0d early_done", k), 32'(early), 32'd0);
        tick();
        check($sformatf("k%0d done_pulse", k), 32'(tx_done[k]), 32'd1);
        check($sformatf("k%0d done_ready", k), 32'(tx_ready[k]), 32'd1);
        done_at = cyc;
        if (!keep_valid) begin
            tick();
            check($sformatf("k%0d done_width", k), 32'(tx_done[k]), 32'd0);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        logic [11:0] bits;
        int         n;
        int         done_t;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint d1, d2, dx;
        int n_done;
        int n_low;
        logic [7:0] rd;
        logic [11:0] rbits;
        int rn;

        vecs[0] = '{k: 0, d: 8'h55, bits: 12'h2AA, n: 10, done_t: 4340};
        vecs[1] = '{k: 1, d: 8'h07, bits: 12'h60E, n: 11, done_t: 4774};
        vecs[2] = '{k: 2, d: 8'h07, bits: 12'h40E, n: 11, done_t: 4774};
        vecs[3] = '{k: 0, d: 8'hA3, bits: 12'h346, n: 10, done_t: 4340};

        rst_n = 1'b0;
        tx_valid = '0;
        for (int k = 0; k < 5; k++) tx_data[k] = '0;
        repeat (3) tick();
        check("rst txd", 32'(txd), 32'h1F);
        check("rst ready", 32'(tx_ready), 32'h1F);
        check("rst busy", 32'(tx_busy), 32'h00);
        check("rst done", 32'(tx_done), 32'h00);
        rst_n = 1'b1;
        tick();
        check("post_rst txd", 32'(txd), 32'h1F);

        for (int v = 0; v < 4; v++)
            send_frame(vecs[v].k, vecs[v].d, vecs[v].bits, vecs[v].n, vecs[v].done_t, 1'b0, 1'b0, dx);

        // Back-to-back streaming with tx_valid held high
        send_frame(0, 8'hA3, 12'h346, 10, 4340, 1'b1, 1'b0, d1);
        send_frame(0, 8'h0F, 12'h21E, 10, 4340, 1'b0, 1'b0, d2);
        check("b2b done spacing", 32'(d2 - d1), 32'd4341);

        // Request with different data while busy must not disturb the frame
        send_frame(0, 8'h3C, 12'h278, 10, 4340, 1'b0, 1'b1, dx);
        n_done = 0;
        repeat (900) begin
            tick();
            if (tx_done[0]) n_done++;
        end
        check("glitch extra done", 32'(n_done), 32'd0);
        check("glitch idle", 32'(tx_busy[0]), 32'd0);

        // Reset pulse in the middle of data bit 3
        tx_data[0]  = 8'hC6;
        tx_valid[0] = 1'b1;
        tick();
        tx_valid[0] = 1'b0;
        check("rstmid accept", 32'(tx_busy[0]), 32'd1);
        repeat (4 * 434 + 217) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid txd", 32'(txd[0]), 32'd1);
        check("rstmid ready", 32'(tx_ready[0]), 32'd1);
        check("rstmid busy", 32'(tx_busy[0]), 32'd0);
        check("rstmid done", 32'(tx_done[0]), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_done = 0;
        n_low = 0;
        repeat (11 * 434) begin
            tick();
            if (tx_done[0]) n_done++;
            if (!txd[0]) n_low++;
        end
        check("rstmid no done", 32'(n_done), 32'd0);
        check("rstmid line idle", 32'(n_low), 32'd0);
        send_frame(0, 8'h81, 12'h302, 10, 4340, 1'b0, 1'b0, dx);

        // Random loopback through the receiver model
        for (int k = 3; k < 5; k++) begin
            for (int r = 0; r < 128; r++) begin
                rd = 8'($urandom);
                model_frame(rd, ub_of(k), par_of(k), rbits, rn);
                send_frame(k, rd, rbits, rn, rn * m_of(k), 1'b0, 1'b0, dx);
                repeat ($urandom_range(0, 3)) tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
